sram22_256x32m4w8_arb: RTL and testbench
========================================

Name: sram22_256x32m4w8_arb

Overview:
Round-robin arbiter sharing one sram22_256x32m4w8 single-port macro (256 x 32b, 4 byte-lane write mask, 1-cycle registered read) between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a buffered valid/ready read-response channel.
- Sits between client blocks and the macro; the macro's clk/we/wmask/addr/din/dout connect directly to this block's sram_* ports.

Parameters:
DATA_WIDTH, 32, word width; must match macro.
ADDR_WIDTH, 8, word address width; must match macro.
WMASK_WIDTH, 4, byte-lane mask width (DATA_WIDTH/8).
NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
clk  input  1  clock, shared with macro.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester request accepted (one-hot or zero).
req_we  input  NUM_REQ  1 = write, 0 = read.
req_wmask  input  NUM_REQ*WMASK_WIDTH  byte-lane mask; slice i for requester i; ignored on reads.
req_addr  input  NUM_REQ*ADDR_WIDTH  word address, sliced per requester.
req_wdata  input  NUM_REQ*DATA_WIDTH  write data, sliced per requester.
rsp_valid  output  NUM_REQ  read data valid.
rsp_ready  input  NUM_REQ  consumer accepts read data.
rsp_rdata  output  NUM_REQ*DATA_WIDTH  read data, sliced per requester.
sram_we  output  1  to macro we.
sram_wmask  output  WMASK_WIDTH  to macro wmask.
sram_addr  output  ADDR_WIDTH  to macro addr.
sram_din  output  DATA_WIDTH  to macro din.
sram_dout  input  DATA_WIDTH  from macro dout.

Behaviour:
- Reset: asynchronous on rst_n low. rsp_valid=0, rsp_rdata=0, all in-flight flags=0, priority pointer=NUM_REQ-1 so requester 0 wins first.
- Eligibility, requester i, cycle N:
  - write: req_valid[i]=1.
  - read: req_valid[i]=1, no read in flight for i, and (rsp_valid[i]=0 or rsp_ready[i]=1).
  - At most one outstanding read per requester.
- Grant:
  - One eligible requester per cycle, chosen by rotating priority starting at pointer+1 mod NUM_REQ.
  - req_ready[i]=1 only for the granted index; req_ready is combinational from req_valid/req_we/state.
  - Pointer updates to the granted index on every grant and holds when there is no grant.
- SRAM drive: combinational mux of the granted requester's we/wmask/addr/wdata. The macro registers these at the next clk edge.
  - No grant: sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0. The macro performs a harmless read that is never captured.
  - Read grant: sram_we=0, sram_wmask=0.
  - wmask=0 on a write is accepted and consumes the slot as a no-op write.
- Read pipeline:
  - Read accepted in cycle N sets inflight[i], observed as 1 in cycle N+1.
  - In cycle N+1, sram_dout holds the data; it is captured into the rsp_rdata[i] slice at the N+1/N+2 edge.
  - rsp_valid[i]=1 from cycle N+2. Read latency is 2 cycles, accept to rsp_valid.
  - rsp_rdata[i] holds while rsp_valid[i]=1 and rsp_ready[i]=0.
  - rsp_valid[i] clears on a handshake unless a new capture for i occurs on the same edge; a same-edge capture reloads data and keeps valid=1.
- Write then read: a write to address A in cycle N followed by a read of A in cycle N+1 returns the new data with per-lane merge; the macro's array updates at edge N.
- Read then write:
  - A read granted in N followed by a write granted in N+1 still returns the correct data.
  - Capture samples the pre-edge dout; the macro's X-on-write update lands at the same edge.
- Throughput: one access per cycle. Reads from different requesters may issue back-to-back. The same requester may issue its next read in N+2 at the earliest, or in N+2 with the previous response popped that cycle.
- Reset mid-operation: in-flight reads are dropped with no response. A write already registered by the macro may or may not have completed. The client must re-issue after reset.
- Back-pressure: an unready consumer blocks only its own reads. Its writes, and other requesters, proceed.

Decomposition:
- Package sram22_arb_pkg:
  - DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH constants.
  - IDX_W = $clog2(NUM_REQ) helper.
  - Request struct typedef {we, wmask, addr, wdata}.
- Sub-module sram22_rr_arbiter:
  - Parameter N.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant, grant index.
  - Combinational rotating priority.
  - The top module holds the pointer register, inflight flags and response slots.

Test Plan:
- Reset/idle: rst_n low 3 cycles, no valids -> rsp_valid=0, req_ready=0, sram_we=0 every cycle.
- Single write+read: req0 write addr 0x10, wmask 4'b1111, data 0xDEADBEEF; next cycle read 0x10 -> rsp_valid[0] two cycles after read accept, rsp_rdata0=0xDEADBEEF.
- Byte mask: write 0x11223344 to 0x20 full mask, then 0xAABBCCDD with wmask 4'b0101, then read -> 0x11BB33DD.
- Contention: both requesters continuously reading distinct addresses, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; each gets one response per 2 cycles, with no lost or mismatched data.
- Back-pressure: rsp_ready[1]=0 with rsp_valid[1]=1 -> further reads from req1 not granted; req0 reads and req1 writes still granted; data on rsp_rdata1 is stable until the ready handshake.
- Reset mid-read: assert rst_n low the cycle after a read accept -> rsp_valid stays 0 after reset release; arbitration restarts at requester 0.

Source files
------------

// File: rtl/sram22_arb_pkg.sv
// Shared definitions for the sram22_256x32m4w8 round-robin arbiter.
// Contents:
//   MACRO_* widths  - geometry of the sram22_256x32m4w8 macro (256 x 32b, 4 lanes)
//   idx_w()         - index width for an N-entry vector (never below 1 bit)
//   sram_req_t      - one requester's command as presented to the macro
package sram22_arb_pkg;

  localparam int MACRO_DATA_WIDTH  = 32;
  localparam int MACRO_ADDR_WIDTH  = 8;
  localparam int MACRO_WMASK_WIDTH = MACRO_DATA_WIDTH / 8;

  // Width of an index into an n-entry vector; a 1-entry vector still needs a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                         we;
    logic [MACRO_WMASK_WIDTH-1:0] wmask;
    logic [MACRO_ADDR_WIDTH-1:0]  addr;
    logic [MACRO_DATA_WIDTH-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/sram22_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// The search starts at ptr+1 (mod N) and wraps, so the last winner has the
// lowest priority on the next decision.
// Ports:
//   eligible  in  [N-1:0]      requesters that may be granted this cycle
//   ptr       in  [IDX_W-1:0]  index of the previous winner
//   grant     out [N-1:0]      one-hot grant, all-zero when nobody is eligible
//   grant_idx out [IDX_W-1:0]  binary index of the grant (0 when no grant)
module sram22_rr_arbiter
  import sram22_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the candidates in rotated order and keep the first eligible one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = IDX_W'((int'(ptr) + k) % N);
      if (!found_s && eligible[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sram22_256x32m4w8_arb.sv
// Round-robin arbiter sharing one sram22_256x32m4w8 single-port macro
// between NUM_REQ requesters. Each requester gets a valid/ready request
// channel and a one-entry buffered valid/ready read-response channel.
// Ports:
//   clk, rst_n                 clock shared with the macro, async active-low reset
//   req_valid/req_ready        per-requester request handshake (ready is one-hot or zero)
//   req_we/req_wmask/req_addr/req_wdata  per-requester command, sliced by requester
//   rsp_valid/rsp_ready/rsp_rdata        per-requester read response
//   sram_we/sram_wmask/sram_addr/sram_din  straight to the macro inputs
//   sram_dout                  macro read data (valid the cycle after a read grant)
module sram22_256x32m4w8_arb
  import sram22_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = MACRO_DATA_WIDTH,
  parameter int ADDR_WIDTH  = MACRO_ADDR_WIDTH,
  parameter int WMASK_WIDTH = MACRO_WMASK_WIDTH,
  parameter int NUM_REQ     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic                          sram_we,
  output logic [WMASK_WIDTH-1:0]        sram_wmask,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout
);

  localparam int IDX_W = idx_w(NUM_REQ);

  sram_req_t            req_s [NUM_REQ];
  sram_req_t            sel_s;
  logic [NUM_REQ-1:0]   eligible_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic                 grant_any_s;

  logic [IDX_W-1:0]     ptr_r;
  logic [NUM_REQ-1:0]   inflight_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [DATA_WIDTH-1:0] rdata_r [NUM_REQ];

  // Unpack the flat per-requester buses into command structs.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_s[i].we    = req_we[i];
      req_s[i].wmask = req_wmask[i*WMASK_WIDTH +: WMASK_WIDTH];
      req_s[i].addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      req_s[i].wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Writes are always eligible. A read needs a free response slot by the time
  // its data lands: nothing in flight, and the slot empty or being popped now.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid[i] &
                      (req_we[i] | (~inflight_r[i] & (~rsp_valid_r[i] | rsp_ready[i])));
    end
  end

  sram22_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .eligible  (eligible_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign grant_any_s = |grant_s;
  assign req_ready   = grant_s;

  // Drive the macro from the winner; idle cycles present an all-zero read
  // whose output is never captured.
  always_comb begin
    sel_s      = req_s[grant_idx_s];
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (grant_any_s) begin
      sram_we    = sel_s.we;
      sram_wmask = sel_s.we ? sel_s.wmask : {WMASK_WIDTH{1'b0}};
      sram_addr  = sel_s.addr;
      sram_din   = sel_s.wdata;
    end else begin
      sram_we = 1'b0;
    end
  end

  // Priority pointer: remembers the last winner, holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= IDX_W'(NUM_REQ - 1);
    end else if (grant_any_s) begin
      ptr_r <= grant_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // In-flight flags: a read granted this cycle has its data on sram_dout next
  // cycle, which is exactly when the flag is set; it lives for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= '0;
    end else begin
      inflight_r <= grant_s & ~req_we;
    end
  end

  // Response slots: capture the pre-edge macro output for in-flight reads.
  // A capture wins over a same-edge pop so reloaded data stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rdata_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inflight_r[i]) begin
          rsp_valid_r[i] <= 1'b1;
          rdata_r[i]     <= sram_dout;
        end else if (rsp_valid_r[i] && rsp_ready[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end else begin
          rsp_valid_r[i] <= rsp_valid_r[i];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_r;

  // Flatten the response slots onto the sliced output bus.
  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_r[i];
    end
  end

endmodule

// File: tb/tb_sram22_256x32m4w8_arb.sv
// Self-checking bench for sram22_256x32m4w8_arb: a macro emulation on the
// sram_* pins, a transaction-level reference model checked every cycle, and
// directed scenarios with literal expected values.
module tb_sram22_256x32m4w8_arb;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NR*MW-1:0]  req_wmask;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata, rsp_rdata;
  logic              sram_we;
  logic [MW-1:0]     sram_wmask;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_din, sram_dout;

  sram22_256x32m4w8_arb #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WMASK_WIDTH (MW), .NUM_REQ (NR)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_wmask (req_wmask), .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .sram_we (sram_we), .sram_wmask (sram_wmask), .sram_addr (sram_addr),
    .sram_din (sram_din), .sram_dout (sram_dout)
  );

  // Macro emulation: registered read, lane-masked write, junk on a write cycle.
  logic [DW-1:0] mac_mem [256];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int b = 0; b < MW; b++) begin
        if (sram_wmask[b]) mac_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end
    end
    sram_dout <= sram_we ? 32'hBAD0_BAD0 : mac_mem[sram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, last winner, one pending read per requester.
  logic [DW-1:0] ref_mem [256];
  int            m_last;
  int            m_cyc = 0;
  bit            m_pend [NR];
  int            m_due  [NR];
  logic [DW-1:0] m_pend_data [NR];
  bit            m_val  [NR];
  logic [DW-1:0] m_data [NR];
  logic [NR-1:0] m_elig, m_gnt;
  int            m_g, m_c;
  logic [DW-1:0] m_lane;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_last = NR - 1;
      for (int i = 0; i < NR; i++) begin
        m_pend[i] = 1'b0;
        m_val[i]  = 1'b0;
      end
      chk("rst_rdata", rsp_rdata, '0);
    end
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rsp_valid%0d", i), rsp_valid[i], m_val[i]);
      if (m_val[i]) chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i*DW +: DW], m_data[i]);
    end
    for (int i = 0; i < NR; i++) begin
      m_elig[i] = req_valid[i] && (req_we[i] || (!m_pend[i] && (!m_val[i] || rsp_ready[i])));
    end
    m_g = -1;
    for (int k = 1; k <= NR; k++) begin
      m_c = (m_last + k) % NR;
      if (m_g < 0 && m_elig[m_c]) m_g = m_c;
    end
    m_gnt = (m_g >= 0) ? (NR'(1) << m_g) : '0;
    chk("req_ready", req_ready, m_gnt);
    if (m_g >= 0) begin
      chk("sram_we", sram_we, req_we[m_g]);
      chk("sram_addr", sram_addr, req_addr[m_g*AW +: AW]);
      chk("sram_wmask", sram_wmask, req_we[m_g] ? req_wmask[m_g*MW +: MW] : 4'h0);
      if (req_we[m_g]) chk("sram_din", sram_din, req_wdata[m_g*DW +: DW]);
    end else begin
      chk("idle_sram", {sram_we, sram_wmask, sram_addr, sram_din}, '0);
    end
    if (rst_n) begin
      if (m_g >= 0) begin
        m_last = m_g;
        if (req_we[m_g]) begin
          for (int b = 0; b < MW; b++) m_lane[8*b +: 8] = {8{req_wmask[m_g*MW + b]}};
          ref_mem[req_addr[m_g*AW +: AW]] = (ref_mem[req_addr[m_g*AW +: AW]] & ~m_lane) |
                                            (req_wdata[m_g*DW +: DW] & m_lane);
        end else begin
          m_pend[m_g]      = 1'b1;
          m_due[m_g]       = m_cyc + 2;
          m_pend_data[m_g] = ref_mem[req_addr[m_g*AW +: AW]];
        end
      end
      for (int i = 0; i < NR; i++) if (m_val[i] && rsp_ready[i]) m_val[i] = 1'b0;
      m_cyc++;
      for (int i = 0; i < NR; i++) begin
        if (m_pend[i] && m_due[i] == m_cyc) begin
          m_val[i]  = 1'b1;
          m_data[i] = m_pend_data[i];
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int i, input bit we, input logic [3:0] m,
                       input logic [7:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    req_we[i] = we;
    req_wmask[i*MW +: MW] = m;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    chk($sformatf("accept%0d_%h", i, a), ok, 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Called the cycle after a read accept: expects rsp_valid two cycles after accept.
  task automatic wait_rsp(input int i, input logic [31:0] exp, input string name);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[i]) got = 1'b1;
    end
    chk({name, "_lat"}, lat, 2);
    chk({name, "_data"}, rsp_rdata[i*DW +: DW], exp);
    @(posedge clk); #1;
  endtask

  int            gseq [$];
  int            nresp [NR];
  int            ka [NR];
  logic [NR-1:0] took;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_wmask = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_we", sram_we, 1'b0);
      chk("rst_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // single write then read
    issue(0, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF);
    issue(0, 1'b0, 4'h0, 8'h10, 32'h0);
    wait_rsp(0, 32'hDEAD_BEEF, "rd10");

    // byte mask merge
    issue(0, 1'b1, 4'hF, 8'h20, 32'h1122_3344);
    issue(0, 1'b1, 4'h5, 8'h20, 32'hAABB_CCDD);
    issue(0, 1'b0, 4'h0, 8'h20, 32'h0);
    wait_rsp(0, 32'h11BB_33DD, "mask");

    // read then write to the same word
    issue(0, 1'b0, 4'h0, 8'h20, 32'h0);
    issue(0, 1'b1, 4'hF, 8'h20, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rdwr_valid", rsp_valid[0], 1'b1);
    chk("rdwr_data", rsp_rdata[31:0], 32'h11BB_33DD);
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h0, 8'h20, 32'h0);
    wait_rsp(0, 32'hCAFE_F00D, "wrnew");

    // zero-mask write is a no-op
    issue(0, 1'b1, 4'h0, 8'h20, 32'hFFFF_FFFF);
    issue(0, 1'b0, 4'h0, 8'h20, 32'h0);
    wait_rsp(0, 32'hCAFE_F00D, "nomask");

    // preload via requester 1, leaving it as the last winner
    for (int k = 0; k < 8; k++) issue(1, 1'b1, 4'hF, 8'(8'h30 + k), 32'h1000_0000 + 32'(k) * 32'h101);

    // contention: both read continuously
    for (int i = 0; i < NR; i++) begin
      ka[i] = 0; nresp[i] = 0;
      req_we[i] = 1'b0;
      req_addr[i*AW +: AW] = 8'(8'h30 + 4*i);
    end
    req_valid = 2'b11;
    repeat (12) begin
      @(negedge clk);
      took = req_ready;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) gseq.push_back(i);
        if (rsp_valid[i]) nresp[i]++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (took[i]) begin
          ka[i] = (ka[i] + 1) % 4;
          req_addr[i*AW +: AW] = 8'(8'h30 + 4*i + ka[i]);
        end
      end
    end
    req_valid = 2'b00;
    chk("cont_ngrant", gseq.size(), 12);
    chk("cont_g0", gseq[0], 0);
    chk("cont_g1", gseq[1], 1);
    chk("cont_g2", gseq[2], 0);
    chk("cont_g3", gseq[3], 1);
    chk("cont_nrsp0", nresp[0], 5);
    chk("cont_nrsp1", nresp[1], 5);
    repeat (4) @(posedge clk);
    #1;

    // back-pressure on requester 1
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 4'h0, 8'h31, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", rsp_valid[1], 1'b1);
    chk("bp_data", rsp_rdata[63:32], 32'h1000_0101);
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_addr[15:8] = 8'h32; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("bp_block", req_ready[1], 1'b0);
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h0, 8'h33, 32'h0);
    wait_rsp(0, 32'h1000_0303, "bp_other");
    req_we[1] = 1'b1; req_wmask[7:4] = 4'hF; req_addr[15:8] = 8'h40; req_wdata[63:32] = 32'h55AA_55AA;
    @(negedge clk);
    chk("bp_write", req_ready[1], 1'b1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_hold", rsp_rdata[63:32], 32'h1000_0101);
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_pop", rsp_valid[1], 1'b0);
    @(posedge clk); #1;
    issue(1, 1'b0, 4'h0, 8'h40, 32'h0);
    wait_rsp(1, 32'h55AA_55AA, "bp_wr");

    // reset the cycle after a read accept
    issue(0, 1'b0, 4'h0, 8'h10, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_drop", rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    req_we = 2'b00; req_addr = {8'h20, 8'h10}; req_valid = 2'b11;
    @(negedge clk);
    chk("rst_first", req_ready, 2'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_second", req_ready, 2'b10);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
